// File: rtl/game_sequencer.sv
// 2048 game flow controller: welcome, tile spawn, move handshake, board check, game over.
// Define GAME_WIN_DETECT_EN to add the WIN state reached when a 2048 tile (value 11) appears.
module game_sequencer #(
  parameter int SPAWN_TRIES      = 32,
  parameter int MOVE_TIMEOUT     = 255,
  parameter int OVER_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_rising_edge,
  input  logic [3:0]  lfsr_out,
  input  logic        rand_four,
  input  logic        btn_valid,
  input  logic [1:0]  btn_dir,
  input  logic [63:0] welcome_grid,
  output logic        mv_start,
  output logic [1:0]  mv_dir,
  input  logic        mv_done,
  input  logic [63:0] mv_result,
  output logic [63:0] grid,
  output logic [2:0]  state,
  output logic        game_over,
  output logic        win
);

  // state     | meaning
  // WELCOME   | show welcome animation, wait for a press
  // SPAWN     | place spawn_left new tiles
  // IDLE      | wait for a direction press
  // MOVE_WAIT | move engine busy, wait for mv_done or timeout
  // CHECK     | evaluate board for win / no-moves-left
  // GAMEOVER  | hold for a number of frames, then a press restarts
  // WIN       | as GAMEOVER, only with the win feature
  typedef enum logic [2:0] {
    S_WELCOME   = 3'd0,
    S_SPAWN     = 3'd1,
    S_IDLE      = 3'd2,
    S_MOVE_WAIT = 3'd3,
    S_CHECK     = 3'd4,
    S_GAMEOVER  = 3'd5
`ifdef GAME_WIN_DETECT_EN
    , S_WIN     = 3'd6
`endif
  } state_t;

  localparam int TW = $clog2(SPAWN_TRIES + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam int FW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [TW-1:0] TRIES_MAX  = TW'(SPAWN_TRIES);
  localparam logic [MW-1:0] MOVE_MAX   = MW'(MOVE_TIMEOUT);
  localparam logic [FW-1:0] FRAMES_MAX = FW'(OVER_HOLD_FRAMES);

  state_t        st, st_next;
  logic [63:0]   grid_r, grid_next;
  logic [1:0]    spawn_left, spawn_left_next;
  logic [TW-1:0] try_cnt, try_next;
  logic [MW-1:0] move_cnt, move_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic          mv_start_r, mv_start_next;
  logic [1:0]    mv_dir_r, mv_dir_next;

  logic          any_empty, any_pair, any_win;
  logic [3:0]    low_idx, write_idx;
  logic          write_en;
  logic [3:0]    probe, spawn_val;

  assign probe     = grid_r[{lfsr_out, 2'b00} +: 4];
  assign spawn_val = rand_four ? 4'd2 : 4'd1;

  // Board scan: lowest empty cell, adjacent equal pairs (rows never wrap), 2048 tile
  always_comb begin
    any_empty = 1'b0;
    low_idx   = 4'd0;
    any_pair  = 1'b0;
    any_win   = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (grid_r[4*i +: 4] == 4'd0) begin
        any_empty = 1'b1;
        low_idx   = 4'(i);
      end
      if (grid_r[4*i +: 4] == 4'd11) any_win = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (grid_r[16*r+4*c +: 4] != 4'd0 &&
            grid_r[16*r+4*c +: 4] == grid_r[16*r+4*c+4 +: 4]) any_pair = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (grid_r[4*i +: 4] != 4'd0 && grid_r[4*i +: 4] == grid_r[4*i+16 +: 4]) any_pair = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_WELCOME;
      grid_r     <= '0;
      spawn_left <= '0;
      try_cnt    <= '0;
      move_cnt   <= '0;
      frame_cnt  <= '0;
      mv_start_r <= 1'b0;
      mv_dir_r   <= 2'd0;
    end else begin
      st         <= st_next;
      grid_r     <= grid_next;
      spawn_left <= spawn_left_next;
      try_cnt    <= try_next;
      move_cnt   <= move_next;
      frame_cnt  <= frame_next;
      mv_start_r <= mv_start_next;
      mv_dir_r   <= mv_dir_next;
    end
  end

  always_comb begin
    st_next         = st;
    grid_next       = grid_r;
    spawn_left_next = spawn_left;
    try_next        = try_cnt;
    move_next       = '0;
    frame_next      = '0;
    mv_start_next   = 1'b0;
    mv_dir_next     = mv_dir_r;
    write_en        = 1'b0;
    write_idx       = lfsr_out;
    case (st)
      S_WELCOME: begin
        grid_next = welcome_grid;
        if (btn_valid) begin
          grid_next       = '0;
          spawn_left_next = 2'd2;
          try_next        = '0;
          st_next         = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (!any_empty) begin
          st_next = S_GAMEOVER;
        end else if (spawn_left == 2'd0) begin
          st_next = S_CHECK;
        end else if (try_cnt >= TRIES_MAX) begin
          write_en  = 1'b1;
          write_idx = low_idx;
        end else if (probe == 4'd0) begin
          write_en = 1'b1;
        end else begin
          try_next = try_cnt + TW'(1);
        end
        if (write_en) begin
          grid_next[{write_idx, 2'b00} +: 4] = spawn_val;
          spawn_left_next = spawn_left - 2'd1;
          try_next        = '0;
          if (spawn_left == 2'd1) st_next = S_CHECK;
        end
      end
      S_IDLE: begin
        if (btn_valid) begin
          mv_dir_next   = btn_dir;
          mv_start_next = 1'b1;
          st_next       = S_MOVE_WAIT;
        end
      end
      S_MOVE_WAIT: begin
        if (mv_done) begin
          if (mv_result != grid_r) begin
            grid_next       = mv_result;
            spawn_left_next = 2'd1;
            try_next        = '0;
            st_next         = S_SPAWN;
          end else begin
            st_next = S_IDLE;
          end
        end else if (move_cnt >= MOVE_MAX) begin
          st_next = S_IDLE;
        end else begin
          move_next = move_cnt + MW'(1);
        end
      end
      S_CHECK: begin
        if (!any_empty && !any_pair) st_next = S_GAMEOVER;
        else                         st_next = S_IDLE;
`ifdef GAME_WIN_DETECT_EN
        if (any_win) st_next = S_WIN;
`endif
      end
`ifdef GAME_WIN_DETECT_EN
      S_GAMEOVER, S_WIN: begin
`else
      S_GAMEOVER: begin
`endif
        frame_next = frame_cnt;
        if (vsync_rising_edge && frame_cnt < FRAMES_MAX) frame_next = frame_cnt + FW'(1);
        if (btn_valid && frame_cnt >= FRAMES_MAX) begin
          frame_next = '0;
          st_next    = S_WELCOME;
        end
      end
      default: st_next = S_WELCOME;
    endcase
  end

  always_comb begin
    grid      = grid_r;
    state     = st;
    mv_start  = mv_start_r;
    mv_dir    = mv_dir_r;
    game_over = (st == S_GAMEOVER);
`ifdef GAME_WIN_DETECT_EN
    win       = (st == S_WIN);
`else
    win       = 1'b0 & any_win;
`endif
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level 2048 game controller. It owns the 64-bit grid register: 16 cells of 4 bits each, cell i at grid[4i+:4], value v means tile 2^v, and 0 means empty. It sequences the flow welcome → spawn → move → spawn/check → game over, and is the only writer of the grid. It drives the external move engine through a start/done handshake and feeds grid to the VGA renderer.

Parameters:
SPAWN_TRIES, 32, cycles spent probing lfsr_out for an empty cell before falling back to the lowest-index empty cell.
MOVE_TIMEOUT, 255, cycles in MOVE_WAIT without mv_done before abort.
OVER_HOLD_FRAMES, 60, vsync rising edges in GAMEOVER before a button is accepted.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
vsync_rising_edge  in  1  one-cycle pulse per frame
lfsr_out  in  4  random cell index, advances every cycle
rand_four  in  1  random bit: 1 = spawn value 2 (a "4" tile), 0 = value 1
btn_valid  in  1  one-cycle pulse, debounced direction press
btn_dir  in  2  0 up, 1 down, 2 left, 3 right; valid with btn_valid
welcome_grid  in  64  animation grid from the welcome-screen generator
mv_start  out  1  one-cycle pulse requesting a move
mv_dir  out  2  latched direction, stable while in MOVE_WAIT
mv_done  in  1  one-cycle pulse, move result valid
mv_result  in  64  grid after the move
grid  out  64  current grid (registered)
state  out  3  FSM state (debug/renderer)
game_over  out  1  high in GAMEOVER
win  out  1  high in WIN (tied 0 when the feature is off)

Behaviour:
- Reset values: state=WELCOME(0), grid=0, mv_start=0, mv_dir=0, game_over=0, win=0. All internal counters are 0.
- State encoding: WELCOME=0, SPAWN=1, IDLE=2, MOVE_WAIT=3, CHECK=4, GAMEOVER=5, WIN=6.
- **WELCOME:** grid<=welcome_grid every cycle. On btn_valid: grid<=0, spawn_left<=2, go to SPAWN. The direction is discarded.
- **SPAWN, random probe:** each cycle, if cell lfsr_out is 0, write {rand_four?2:1} there, decrement spawn_left and reset the try counter. Otherwise increment the try counter.
- **SPAWN, fallback:** when the try counter reaches SPAWN_TRIES, write the lowest-index empty cell that cycle.
- **SPAWN, full board:** if no cell is empty at any point, go to GAMEOVER.
- **SPAWN, exit:** when spawn_left becomes 0, go to CHECK on the next cycle.
- **IDLE:** on btn_valid: mv_dir<=btn_dir, mv_start<=1 for exactly one cycle (the cycle after btn_valid), go to MOVE_WAIT. mv_start is 0 at all other times.
- **MOVE_WAIT, mv_done high:**
  - if mv_result != grid: grid<=mv_result, spawn_left<=1, go to SPAWN.
  - otherwise (illegal move): grid unchanged, go to IDLE with no spawn.
- **MOVE_WAIT, timeout:** after MOVE_TIMEOUT cycles with no mv_done, go to IDLE with grid unchanged.
- **CHECK:** single cycle, combinational evaluation of grid. If no empty cell and no horizontally or vertically adjacent equal nonzero pair, go to GAMEOVER; else go to IDLE. Row r is cells 4r..4r+3. Horizontal pairs never wrap between rows.
- **GAMEOVER:** game_over=1. Count vsync_rising_edge up to OVER_HOLD_FRAMES. Once reached, btn_valid moves to WELCOME and clears game_over. Earlier presses are ignored.
- **Ignored inputs:**
  - btn_valid in SPAWN, MOVE_WAIT and CHECK is dropped; no queuing.
  - mv_done outside MOVE_WAIT is ignored.
- **Simultaneous btn_valid and mv_done in MOVE_WAIT:** mv_done is processed, the button is dropped.
- **rst mid-operation:** rst in any state, including mid-handshake, returns to reset values on the next edge. A late mv_done after reset is ignored.
- **Counter widths:** sized for their parameter and saturating. No wrap.

Optional Feature:
GAME_WIN_DETECT_EN
- Defined: in CHECK, if any cell equals 11, go to WIN (priority over the GAMEOVER and IDLE decisions). WIN holds win=1 and grid frozen. After OVER_HOLD_FRAMES vsync edges, btn_valid goes to WELCOME.
- Undefined: no WIN state, win tied 0, play continues past 2048.

Test Plan:
- Reset then btn_valid in WELCOME → grid=0 the cycle after, then exactly 2 nonzero cells of value 1 or 2, then state=IDLE.
- IDLE, btn_dir=2 → mv_start high for exactly one cycle, mv_dir=2. Return mv_result with one cell changed → grid=mv_result plus one new tile, state returns to IDLE.
- mv_result == grid → no spawn, grid unchanged, state IDLE one cycle after mv_done. No mv_done for 255 cycles → IDLE, grid unchanged.
- lfsr_out stuck at 5, cell 5 occupied, only cell 9 empty → after 32 cycles cell 9 is written. Board full after spawn with pattern 1,2,1,2/2,1,2,1/... → GAMEOVER, game_over=1.
- In GAMEOVER, press button after 10 vsyncs → ignored. After 60 vsyncs → WELCOME, game_over=0. rst asserted during MOVE_WAIT → state 0, grid 0.
- With GAME_WIN_DETECT_EN, a move creating value 11 → after spawn, state=WIN, win=1. Without the macro → state IDLE, win=0.
